// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_ASSEMBLE = 2'd1;
    localparam state_t ST_WRITE    = 2'd2;
    localparam state_t ST_DONE     = 2'd3;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_STRIDE    = 4;

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; word_full marks the byte that completes it.
module word_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  byte_idx;
    logic [31:0] word_q;

    // Next word with the incoming byte already merged, so the completing byte
    // can be written out in the same edge it is accepted.
    always_comb begin
        word_next = word_q;
        word_next[{byte_idx, 3'b000} +: 8] = byte_data;
    end

    assign word_full = byte_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + 2'd1;
            word_q   <= word_next;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams bytes into instruction memory one word at a time and
// holds the core in reset until the requested number of words is resident.
//
// state    | meaning
// ST_IDLE  | waiting for a valid start; core held in reset
// ST_ASSEMBLE | accepting bytes into the current word
// ST_WRITE | one-cycle memory write of the assembled word
// ST_DONE  | program resident, core released; start may reload
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_rst_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_cnt_nxt;
    logic             count_ok;
    logic             start_ok;
    logic             byte_en;
    logic             word_full;
    logic [31:0]      word_next;

    assign count_ok     = (num_words != '0) && (num_words <= CNT_W'(DEPTH));
    assign start_ok     = start && count_ok && ((state == ST_IDLE) || (state == ST_DONE));
    assign byte_en      = (state == ST_ASSEMBLE) && byte_valid && byte_ready;
    assign word_cnt_nxt = word_cnt + 1'b1;

    word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .byte_en   (byte_en),
        .byte_data (byte_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count_q    <= '0;
            word_cnt   <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (count_ok) begin
                            err        <= 1'b0;
                            count_q    <= num_words;
                            word_cnt   <= '0;
                            mem_waddr  <= '0;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            cpu_rst_n  <= 1'b0;
                            byte_ready <= 1'b1;
                            state      <= ST_ASSEMBLE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_ASSEMBLE: begin
                    if (word_full) begin
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_wdata  <= word_next;
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    mem_we   <= 1'b0;
                    word_cnt <= word_cnt_nxt;
                    // Address stays on the last word so it never passes 4*(DEPTH-1).
                    if (word_cnt_nxt == count_q) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        mem_waddr  <= mem_waddr + 32'(ADDR_STRIDE);
                        byte_ready <= 1'b1;
                        state      <= ST_ASSEMBLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader against a byte-queue reference model.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [7:0]  fixed_bytes[4] = '{8'h13, 8'h05, 8'h50, 8'h00};
    logic        we_q   = 1'b0;
    logic        done_q = 1'b0;

    always #5 clk = ~clk;

    imem_boot_loader #(.DEPTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Write monitor: records every write and flags protocol breaks
    // (byte_ready high on a write, multi-cycle write pulse, done not right after a write).
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                obs_addr.push_back(mem_waddr);
                obs_data.push_back(mem_wdata);
                if (byte_ready) viol++;
                if (we_q) viol++;
            end
            if (done && !done_q && !we_q) viol++;
        end
        we_q   = rst_n && mem_we;
        done_q = rst_n && done;
    end

    task automatic new_load();
        exp_bytes.delete();
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_words = 6'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic feed(input int nbytes, input int stall_pct, input int mid_start_at, input bit fixed);
        int idx = 0;
        int cyc = 0;
        while (idx < nbytes && cyc < nbytes * 20 + 50) begin
            byte_valid = ($urandom_range(0, 99) >= stall_pct);
            byte_data  = fixed ? fixed_bytes[idx % 4] : 8'($urandom);
            start      = (idx == mid_start_at);
            num_words  = 6'($urandom_range(0, 40));
            if (byte_valid && byte_ready) begin
                exp_bytes.push_back(byte_data);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check("feed_complete", 32'(idx), 32'(nbytes));
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("done", 32'(done), 32'd1);
        check("cpu_rst_n_released", 32'(cpu_rst_n), 32'd1);
        check("busy_clear", 32'(busy), 32'd0);
        check("err_clear", 32'(err), 32'd0);
    endtask

    task automatic check_writes(input int n);
        logic [31:0] w;
        check("we_pulses", 32'(obs_addr.size()), 32'(n));
        for (int i = 0; i < n && i < obs_addr.size() && 4 * i + 3 < exp_bytes.size(); i++) begin
            w = {exp_bytes[4*i+3], exp_bytes[4*i+2], exp_bytes[4*i+1], exp_bytes[4*i]};
            check($sformatf("waddr[%0d]", i), obs_addr[i], 32'(4 * i));
            check($sformatf("wdata[%0d]", i), obs_data[i], w);
        end
        check("protocol_viol", 32'(viol), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_waddr"}, mem_waddr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        num_words  = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Rejected count from IDLE
        new_load();
        do_start(0);
        check("idle_bad0_err", 32'(err), 32'd1);
        check("idle_bad0_busy", 32'(busy), 32'd0);

        // Single known word
        new_load();
        do_start(1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(byte_ready), 32'd1);
        check("start_err_cleared", 32'(err), 32'd0);
        feed(4, 0, -1, 1'b1);
        wait_done();
        check_writes(1);
        if (obs_data.size() > 0) check("single_wdata", obs_data[0], 32'h0050_0513);

        // Rejected counts while DONE: err set, core stays released
        new_load();
        do_start(0);
        check("done_bad0_err", 32'(err), 32'd1);
        check("done_bad0_busy", 32'(busy), 32'd0);
        check("done_bad0_done", 32'(done), 32'd1);
        do_start(33);
        check("done_bad33_err", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        check("bad_no_we", 32'(obs_addr.size()), 32'd0);

        // Reload from DONE
        new_load();
        do_start(2);
        check("reload_done_low", 32'(done), 32'd0);
        check("reload_cpu_rst_low", 32'(cpu_rst_n), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
        check("reload_err", 32'(err), 32'd0);
        feed(8, 30, -1, 1'b0);
        wait_done();
        check_writes(2);

        // Multi-word with stalls and a start pulsed mid-load
        new_load();
        do_start(3);
        feed(12, 40, 5, 1'b0);
        wait_done();
        check_writes(3);

        // Reset after two bytes of word 1
        new_load();
        do_start(3);
        feed(6, 20, -1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midload_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        new_load();
        do_start(1);
        feed(4, 20, -1, 1'b0);
        wait_done();
        check_writes(1);

        // Full depth
        new_load();
        do_start(32);
        feed(128, 25, -1, 1'b0);
        wait_done();
        check_writes(32);
        if (obs_addr.size() == 32) check("last_addr", obs_addr[31], 32'h7C);
        check("final_addr_bound", mem_waddr, 32'h7C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
